// File: rtl/leaf_rx_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_rx_stream_bridge_pkg
//  Description : Shared leaf-interface definitions. Holds the capture FSM
//                state encoding and the default buffer depth used by the
//                leaf RX stream bridge and its FIFO.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package leaf_rx_stream_bridge_pkg;

  // Default number of buffered words between the leaf interface and the user
  localparam int unsigned LEAF_FIFO_DEPTH_DEFAULT = 4;

  // Capture FSM encoding, kept as plain sized constants for legacy tools
  localparam logic [0:0] ST_WAIT_VLD = 1'b0;
  localparam logic [0:0] ST_COOLDOWN = 1'b1;

  // True when depth is a power of two and at least 2
  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : leaf_rx_stream_bridge_pkg
`default_nettype wire

// File: rtl/leaf_rx_stream_bridge_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fwft_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head word is
//                presented combinationally; occupancy is a registered count.
//                Storage is not reset, only pointers and count are.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                push       - write push_data this edge (caller ensures !full)
//                push_data  - word to write
//                pop        - retire head word this edge (caller ensures !empty)
//                pop_data   - head word (valid while occupancy != 0)
//                occupancy  - number of stored words, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fwft_fifo
  import leaf_rx_stream_bridge_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    pop_data,
  output logic [PTR_BITS:0]   occupancy
);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("sync_fwft_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   count_q,  count_d;

  // Power-of-two depth lets the pointers wrap naturally at their width
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
      2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule : sync_fwft_fifo
`default_nettype wire

// File: rtl/leaf_rx_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_rx_stream_bridge
//  Description : Captures words from a leaf-interface IN port, returns a
//                one-cycle ack per captured word, and buffers them in a FWFT
//                FIFO presented as a valid/ready stream. A cooldown cycle
//                after each capture limits intake to one word per 2 cycles.
//  Ports       : clk                      - rising-edge clock
//                reset                    - asynchronous active-low reset
//                din_leaf_interface2user  - leaf data word
//                vld_interface2user       - leaf word valid
//                ack_user2interface       - registered one-cycle pop pulse
//                m_data / m_valid         - user stream data / valid
//                m_ready                  - user stream ready
//                occupancy                - words held in the FIFO
//                rx_count                 - words accepted, wraps mod 2^32
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_rx_stream_bridge
  import leaf_rx_stream_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = LEAF_FIFO_DEPTH_DEFAULT,
  localparam int PTR_BITS    = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PTR_BITS:0]       occupancy,
  output logic [31:0]             rx_count
);

  logic [0:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       rx_count_q, rx_count_d;
  logic [PTR_BITS:0] occupancy_w;
  logic              capture_w;
  logic              pop_w;

  // Capture only in WAIT_VLD with room left; using the current occupancy
  // means a pop and a capture never coincide when full, so the FIFO can
  // never be written while full.
  assign capture_w = (state_q == ST_WAIT_VLD) && vld_interface2user &&
                     (occupancy_w < (PTR_BITS+1)'(FIFO_DEPTH));
  assign pop_w     = m_valid && m_ready;

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rx_count_d = rx_count_q;
    case (state_q)
      ST_WAIT_VLD: begin
        if (capture_w) begin
          state_d    = ST_COOLDOWN;
          ack_d      = 1'b1;
          rx_count_d = rx_count_q + 32'd1;
        end
      end
      ST_COOLDOWN: begin
        state_d = ST_WAIT_VLD;
      end
      default: begin
        state_d = ST_WAIT_VLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAIT_VLD;
      ack_q      <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rx_count_q <= rx_count_d;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (capture_w),
    .push_data (din_leaf_interface2user),
    .pop       (pop_w),
    .pop_data  (m_data),
    .occupancy (occupancy_w)
  );

  assign m_valid            = (occupancy_w != '0);
  assign occupancy          = occupancy_w;
  assign ack_user2interface = ack_q;
  assign rx_count           = rx_count_q;

endmodule : leaf_rx_stream_bridge
`default_nettype wire

// File: tb/tb_leaf_rx_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leaf_rx_stream_bridge
//  Description : Self-checking bench for leaf_rx_stream_bridge. A small
//                cycle model predicts captures, acks, occupancy and rx_count;
//                captured words go into a scoreboard queue and are compared
//                against m_data when the stream pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_rx_stream_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  occupancy;
  logic [31:0] rx_count;

  always #5 clk = ~clk;

  leaf_rx_stream_bridge dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_interface2user (din),
    .vld_interface2user      (vld),
    .ack_user2interface      (ack),
    .m_data                  (m_data),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .occupancy               (occupancy),
    .rx_count                (rx_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          m_occ;
  bit          m_cool;
  bit          m_ack;
  logic [31:0] m_cnt;
  bit          last_cap;
  int          ack_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_occ  = 0;
    m_cool = 0;
    m_ack  = 0;
    m_cnt  = '0;
  endtask

  // Called at a falling edge with inputs already driven: checks outputs,
  // advances the model across the next rising edge, returns at the next fall.
  task automatic cyc();
    bit cap;
    bit pop;
    check_eq("ack", {31'd0, ack}, {31'd0, m_ack});
    check_eq("m_valid", {31'd0, m_valid}, {31'd0, (m_occ != 0)});
    check_eq("occupancy", {29'd0, occupancy}, m_occ);
    check_eq("rx_count", rx_count, m_cnt);
    cap = !m_cool && vld && (m_occ < 4);
    pop = (m_occ != 0) && m_ready;
    if (pop) begin
      if (exp_q.size() == 0) check_eq("underflow", 32'd1, 32'd0);
      else check_eq("m_data", m_data, exp_q.pop_front());
    end
    if (cap) begin
      exp_q.push_back(din);
      m_cnt = m_cnt + 32'd1;
    end
    m_occ    = m_occ + int'(cap) - int'(pop);
    m_cool   = cap;
    m_ack    = cap;
    last_cap = cap;
    @(posedge clk);
    @(negedge clk);
    if (ack) ack_seen++;
  endtask

  // Offer n consecutive words with vld held; returns how many were accepted
  task automatic offer(input logic [31:0] base, input int n, input int budget,
                       input bit rnd_ready, output int got);
    int c = 0;
    got = 0;
    while (got < n && c < budget) begin
      vld = 1'b1;
      din = base + got;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      cyc();
      if (last_cap) got++;
      c++;
    end
    vld = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    vld     = 1'b0;
    m_ready = 1'b1;
    while (m_occ != 0 && c < budget) begin
      cyc();
      c++;
    end
    cyc();
    check_eq("drain_occ", {29'd0, occupancy}, 32'd0);
  endtask

  initial begin
    int got;
    reset   = 1'b0;
    din     = '0;
    vld     = 1'b0;
    m_ready = 1'b0;
    ack_seen = 0;
    model_reset();
    #1;
    check_eq("rst_ack",      {31'd0, ack},       32'd0);
    check_eq("rst_valid",    {31'd0, m_valid},   32'd0);
    check_eq("rst_occ",      {29'd0, occupancy}, 32'd0);
    check_eq("rst_rx_count", rx_count,           32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Scenario 1: single word
    vld = 1'b1; din = 32'hA5A5_0001; m_ready = 1'b1;
    cyc();
    vld = 1'b0;
    check_eq("s1_ack",   {31'd0, ack},     32'd1);
    check_eq("s1_valid", {31'd0, m_valid}, 32'd1);
    check_eq("s1_data",  m_data,           32'hA5A5_0001);
    check_eq("s1_count", rx_count,         32'd1);
    cyc();
    cyc();

    // Scenario 2: streaming 8 words, ready held high
    ack_seen = 0;
    offer(32'd1, 8, 40, 1'b0, got);
    check_eq("s2_accepted", got, 32'd8);
    drain(20);
    check_eq("s2_acks", ack_seen, 32'd8);

    // Scenario 3: backpressure until full, then drain and accept the rest
    m_ready  = 1'b0;
    ack_seen = 0;
    offer(32'd101, 6, 14, 1'b0, got);
    check_eq("s3_accepted", got, 32'd4);
    check_eq("s3_occ", {29'd0, occupancy}, 32'd4);
    check_eq("s3_ack_idle", {31'd0, ack}, 32'd0);
    check_eq("s3_acks", ack_seen, 32'd4);
    m_ready = 1'b1;
    offer(32'd105, 2, 20, 1'b0, got);
    check_eq("s3_rest", got, 32'd2);
    drain(20);

    // Scenario 4: full, pop and offer on the same cycle
    m_ready = 1'b0;
    offer(32'd201, 4, 20, 1'b0, got);
    check_eq("s4_fill", got, 32'd4);
    vld = 1'b1; din = 32'd205; m_ready = 1'b1;
    cyc();
    check_eq("s4_no_cap_when_full", {31'd0, ack}, 32'd0);
    m_ready = 1'b0;
    cyc();
    vld = 1'b0;
    check_eq("s4_cap_next", {31'd0, ack}, 32'd1);
    check_eq("s4_occ", {29'd0, occupancy}, 32'd4);
    drain(20);

    // Scenario 5: reset during cooldown with 3 words buffered
    m_ready = 1'b0;
    offer(32'd301, 3, 20, 1'b0, got);
    check_eq("s5_fill", got, 32'd3);
    check_eq("s5_in_cooldown", {31'd0, ack}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("s5_rst_ack",   {31'd0, ack},       32'd0);
    check_eq("s5_rst_valid", {31'd0, m_valid},   32'd0);
    check_eq("s5_rst_occ",   {29'd0, occupancy}, 32'd0);
    check_eq("s5_rst_count", rx_count,           32'd0);
    model_reset();
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    offer(32'h55, 1, 10, 1'b0, got);
    check_eq("s5_first_valid", {31'd0, m_valid}, 32'd1);
    check_eq("s5_first_data",  m_data,           32'h55);
    drain(20);

    // Scenario 6: rx_count wrap, then pointer wrap under random ready
    force dut.rx_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.rx_count_q;
    m_cnt = 32'hFFFF_FFFF;
    offer(32'h600, 1, 10, 1'b0, got);
    check_eq("s6_wrap_count", rx_count, 32'd0);
    offer(32'h700, 10, 100, 1'b1, got);
    check_eq("s6_accepted", got, 32'd10);
    drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_leaf_rx_stream_bridge
`default_nettype wire

// File: doc/leaf_rx_stream_bridge.md
LEAF_RX_STREAM_BRIDGE -- requirements
Module: leaf_rx_stream_bridge

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 32, giving the data word width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the buffer entries; it SHALL be a power of two, at least 2.
REQ-003 Localparam PTR_BITS SHALL equal log2(FIFO_DEPTH).
REQ-004 Port clk: input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous active-low reset.
REQ-006 Port din_leaf_interface2user: input, PAYLOAD_BITS, one leaf-interface IN-port data word.
REQ-007 Port vld_interface2user: input, 1 bit, the leaf-interface word is valid.
REQ-008 Port ack_user2interface: output, 1 bit, one-cycle pop pulse returned to the leaf interface.
REQ-009 Port m_data: output, PAYLOAD_BITS, user-side stream data.
REQ-010 Port m_valid: output, 1 bit, user-side stream valid.
REQ-011 Port m_ready: input, 1 bit, user-side stream ready.
REQ-012 Port occupancy: output, PTR_BITS+1, current number of words in the FIFO.
REQ-013 Port rx_count: output, 32 bits, total words accepted; it SHALL wrap modulo 2^32.

Function
REQ-014 The capture FSM SHALL have two states: WAIT_VLD and COOLDOWN.
REQ-015 In WAIT_VLD, when vld_interface2user=1 and occupancy<FIFO_DEPTH at a rising edge, the block SHALL write din_leaf_interface2user into the FIFO at wr_ptr on that edge.
REQ-016 On that same edge the block SHALL assert registered ack_user2interface=1 for exactly one cycle and move to COOLDOWN.
REQ-017 COOLDOWN SHALL last exactly one cycle and then return to WAIT_VLD; no capture and no ack SHALL occur in COOLDOWN.
REQ-018 Consequence of REQ-016/017: accepted-word throughput SHALL be at most one word per 2 cycles.
REQ-019 When occupancy==FIFO_DEPTH (full), no capture SHALL occur and ack_user2interface SHALL stay 0; the FSM SHALL stay in WAIT_VLD.
REQ-020 ack_user2interface SHALL never be asserted while vld_interface2user was 0 at the capturing edge.
REQ-021 The FIFO SHALL be first-word-fall-through: m_valid = (occupancy!=0), and m_data = mem[rd_ptr] combinationally.
REQ-022 A pop SHALL occur on an edge where m_valid=1 and m_ready=1; rd_ptr SHALL then advance.
REQ-023 wr_ptr and rd_ptr SHALL be PTR_BITS wide and wrap from FIFO_DEPTH-1 to 0.
REQ-024 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-025 A push while full SHALL be impossible by construction.
REQ-026 A word pushed at edge t SHALL appear on m_data with m_valid=1 in the cycle after edge t, giving latency 1.
REQ-027 rx_count SHALL increment by 1 on every capture edge.
REQ-028 m_data SHALL be don't-care while m_valid=0.

Reset
REQ-029 While reset=0, ack_user2interface, m_valid, occupancy and rx_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 While reset=0, wr_ptr and rd_ptr SHALL be 0 and the FSM SHALL be in WAIT_VLD.
REQ-031 FIFO storage SHALL not be reset.
REQ-032 A reset asserted mid-operation SHALL discard all buffered words and abort any in-flight ack pulse.
REQ-033 The first capture after reset release SHALL require vld_interface2user=1 at a rising edge in WAIT_VLD.

Structure
REQ-034 The FSM state encoding (WAIT_VLD, COOLDOWN) SHALL live in the shared leaf-interface package.
REQ-035 The default FIFO_DEPTH constant SHALL live in the shared leaf-interface package.
REQ-036 The FIFO storage and pointer logic SHALL be one sub-module, sync_fwft_fifo; the FSM, ack generation and rx_count SHALL stay in leaf_rx_stream_bridge.

Verification
REQ-037 Scenario 1: vld=1 with din=0xA5A5_0001 held for 1 cycle, m_ready=1 -> one ack pulse; m_valid=1 with m_data=0xA5A5_0001 the following cycle; rx_count=1.
REQ-038 Scenario 2: vld held high with words 1..8, m_ready=1 -> exactly 8 ack pulses, spaced 2 cycles apart; output order 1..8.
REQ-039 Scenario 3: m_ready=0 and 6 words offered with FIFO_DEPTH=4 -> exactly 4 acks; occupancy=4; ack stays 0; then m_ready=1 -> words 5 and 6 are accepted after drain.
REQ-040 Scenario 4: occupancy=4 (full), m_ready=1 and vld=1 on the same cycle -> the pop occurs; the capture occurs on the next edge; occupancy returns to 4; no word is lost.
REQ-041 Scenario 5: reset asserted during the COOLDOWN cycle with 3 words buffered -> ack, m_valid and occupancy drop to 0 asynchronously; after release, a new word 0x55 is the first word output.
REQ-042 Scenario 6: preload rx_count to 0xFFFF_FFFF by forcing, then one capture -> rx_count=0; the pointer wrap is exercised over 10 words with no data corruption.
